// File: rtl/sub_shift_rows.sv
// sub_shift_rows: iterative AES SubBytes + ShiftRows, SBOX_LANES bytes substituted per cycle.
// Define SUBSHIFT_INV_EN to add the dec port, inverse S-boxes and InvShiftRows.

module sub_shift_rows_sbox_lane (
  input  logic [7:0] din,
`ifdef SUBSHIFT_INV_EN
  input  logic       dec,
`endif
  output logic [7:0] dout
);
  // Element 0 is the most significant byte, so FWD[x] reads straight off the row-major table.
  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] fwd_b;
  assign fwd_b = FWD[din];

`ifdef SUBSHIFT_INV_EN
  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  assign dout = dec ? INV[din] : fwd_b;
`else
  assign dout = fwd_b;
`endif
endmodule

module sub_shift_rows #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef SUBSHIFT_INV_EN
  input  logic         dec,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int N  = 16 / SBOX_LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
        SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
    $error("sub_shift_rows: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q;
  logic [0:15][7:0]            buf_q;   // index = AES byte number (4*col+row)
  logic                        last;
  logic [SBOX_LANES-1:0][3:0]  lane_idx;
  logic [SBOX_LANES-1:0][7:0]  lane_din, lane_dout;
`ifdef SUBSHIFT_INV_EN
  logic                        dec_q;
`endif

  assign last = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bytes are rewritten in place; the lane for byte b is b % SBOX_LANES in round b / SBOX_LANES.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      buf_q <= '0;
`ifdef SUBSHIFT_INV_EN
      dec_q <= 1'b0;
`endif
    end else if (state_q == IDLE && in_valid) begin
      cnt_q <= '0;
      buf_q <= in_state;
`ifdef SUBSHIFT_INV_EN
      dec_q <= dec;
`endif
    end else if (state_q == BUSY) begin
      for (int b = 0; b < 16; b++)
        if (b / SBOX_LANES == int'(cnt_q)) buf_q[b] <= lane_dout[b % SBOX_LANES];
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'(int'(cnt_q) * SBOX_LANES + l);
    assign lane_din[l] = buf_q[lane_idx[l]];
    sub_shift_rows_sbox_lane u_sbox (
      .din  (lane_din[l]),
`ifdef SUBSHIFT_INV_EN
      .dec  (dec_q),
`endif
      .dout (lane_dout[l])
    );
  end

  // Output byte (c,r) takes substituted byte (c+r mod 4, r); inverse mode uses (c-r mod 4, r).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int FB = 4 * ((c + r) % 4) + r;
`ifdef SUBSHIFT_INV_EN
      localparam int IB = 4 * ((c - r + 4) % 4) + r;
      assign out_state[127-8*(4*c+r) -: 8] = dec_q ? buf_q[IB] : buf_q[FB];
`else
      assign out_state[127-8*(4*c+r) -: 8] = buf_q[FB];
`endif
    end
  end
endmodule
